// File: rtl/fir_stream_pipelined.sv
// Streaming transposed-form FIR: run-time loadable double-buffered coefficients, valid/ready flow control.
// Optional macro FIR_SAT_EN: saturate the rounded result to OUT_W bits (default build wraps).
module fir_stream_pipelined #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 32,
  parameter int TAPS      = 102,
  parameter int OUT_SHIFT = 32,
  parameter int OUT_W     = 64,
  // Spare index bit when TAPS is a power of two, so out-of-range indices can be expressed and rejected
  localparam int ADDR_W   = $clog2(TAPS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  dout,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_swap,
  output logic                     swap_pending
);

  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (OUT_SHIFT - 1);

  logic                     en;
  logic                     copy;
  logic signed [DATA_W-1:0] x_q;
  logic                     v1_q, v2_q, v3_q;
  logic signed [COEF_W-1:0] h_shd_q [TAPS];
  logic signed [COEF_W-1:0] h_act_q [TAPS];
  logic signed [ACC_W-1:0]  s_q     [TAPS];
  logic signed [ACC_W-1:0]  s_d     [TAPS];
  logic signed [PROD_W-1:0] prod    [TAPS];
  logic                     swap_pending_q, swap_pending_d;
  logic signed [ACC_W-1:0]  rnd_sum, rnd_shift;
  logic signed [OUT_W-1:0]  dout_q, dout_d;

  assign en           = !v3_q || out_ready;
  assign in_ready     = en;
  assign out_valid    = v3_q;
  assign dout         = dout_q;
  assign swap_pending = swap_pending_q;

  // A swap request is absorbed while pending and applied on the first advancing cycle
  assign copy           = swap_pending_q && en;
  assign swap_pending_d = copy ? 1'b0 : (swap_pending_q || coef_swap);

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      assign prod[gi] = PROD_W'(x_q) * PROD_W'(h_act_q[gi]);
      if (gi == TAPS - 1) begin : g_last
        assign s_d[gi] = ACC_W'(prod[gi]);
      end else begin : g_mid
        assign s_d[gi] = s_q[gi + 1] + ACC_W'(prod[gi]);
      end
    end
  endgenerate

  // Round half toward +inf, then narrow to OUT_W
  assign rnd_sum   = s_q[0] + RND;
  assign rnd_shift = rnd_sum >>> OUT_SHIFT;

  generate
    if (OUT_W >= ACC_W) begin : g_fmt_ext
      assign dout_d = OUT_W'(rnd_shift);
    end else begin : g_fmt_narrow
`ifdef FIR_SAT_EN
      localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
      localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
      always_comb begin
        dout_d = OUT_W'(rnd_shift);
        if (rnd_shift > MAX_V) begin
          dout_d = MAX_V[OUT_W-1:0];
        end else if (rnd_shift < MIN_V) begin
          dout_d = MIN_V[OUT_W-1:0];
        end
      end
`else
      assign dout_d = OUT_W'(rnd_shift);
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q            <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      v3_q           <= 1'b0;
      swap_pending_q <= 1'b0;
      dout_q         <= '0;
      for (int k = 0; k < TAPS; k++) begin
        s_q[k]     <= '0;
        h_shd_q[k] <= '0;
        h_act_q[k] <= '0;
      end
    end else begin
      swap_pending_q <= swap_pending_d;
      // Copy reads the shadow before this cycle's write lands
      for (int k = 0; k < TAPS; k++) begin
        if (coef_we && coef_addr == ADDR_W'(k)) begin
          h_shd_q[k] <= coef_wdata;
        end
        if (copy) begin
          h_act_q[k] <= h_shd_q[k];
        end
      end
      if (en) begin
        x_q  <= din;
        v1_q <= in_valid;
        v2_q <= v1_q;
        v3_q <= v2_q;
        // Chain only moves on real samples so bubbles never shift zeros in
        if (v1_q) begin
          for (int k = 0; k < TAPS; k++) begin
            s_q[k] <= s_d[k];
          end
        end
        if (v2_q) begin
          dout_q <= dout_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_pipelined.sv
// Directed and randomized bench for fir_stream_pipelined against a sample-history reference model.
// Honours FIR_SAT_EN for the expected output narrowing.
`timescale 1ns/1ps
module tb_fir_stream_pipelined;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int TAPS      = 4;
  localparam int OUT_SHIFT = 1;
  localparam int OUT_W     = 16;
  localparam int ADDR_W    = $clog2(TAPS + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] din;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  dout;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_swap;
  logic                     swap_pending;

  int n_cmp = 0;
  int n_bad = 0;

  fir_stream_pipelined #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
    .swap_pending(swap_pending)
  );

  // Reference: each accepted sample remembers the active bank in force when it was taken;
  // result n = sum_k bank(n-k)[k] * x[n-k]. In-flight results age by one per advancing edge.
  typedef struct { longint val; int age; } item_t;
  item_t  pipe_m[$];
  longint act_m [TAPS];
  longint shd_m [TAPS];
  longint hx_m  [TAPS];
  longint hh_m  [TAPS][TAPS];
  bit     pend_m = 1'b0;
  logic signed [OUT_W-1:0] dout_m = '0;

  function automatic bit ov_m();
    if (pipe_m.size() == 0) return 1'b0;
    return pipe_m[0].age == 3;
  endfunction

  function automatic logic signed [OUT_W-1:0] fmt(input longint acc);
    longint r;
    r = (acc + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
    if (r > (longint'(1) <<< (OUT_W - 1)) - 1) r = (longint'(1) <<< (OUT_W - 1)) - 1;
    else if (r < -(longint'(1) <<< (OUT_W - 1))) r = -(longint'(1) <<< (OUT_W - 1));
`endif
    return r[OUT_W-1:0];
  endfunction

  task automatic accept(input longint x);
    longint y = 0;
    item_t  it;
    for (int k = TAPS - 1; k > 0; k--) begin
      hx_m[k] = hx_m[k-1];
      hh_m[k] = hh_m[k-1];
    end
    hx_m[0] = x;
    hh_m[0] = act_m;
    for (int k = 0; k < TAPS; k++) y += hh_m[k][k] * hx_m[k];
    it.val = y;
    it.age = 1;
    pipe_m.push_back(it);
  endtask

  task automatic model_edge();
    bit en;
    bit copy;
    if (!rst_n) begin
      pipe_m.delete();
      for (int k = 0; k < TAPS; k++) begin
        act_m[k] = 0; shd_m[k] = 0; hx_m[k] = 0;
        for (int j = 0; j < TAPS; j++) hh_m[k][j] = 0;
      end
      pend_m = 1'b0;
      dout_m = '0;
      return;
    end
    en   = !ov_m() || out_ready;
    copy = pend_m && en;
    if (en) begin
      if (ov_m()) void'(pipe_m.pop_front());
      foreach (pipe_m[i]) begin
        pipe_m[i].age = pipe_m[i].age + 1;
        if (pipe_m[i].age == 3) dout_m = fmt(pipe_m[i].val);
      end
      if (copy) act_m = shd_m;
      if (in_valid) accept(longint'(din));
    end
    pend_m = copy ? 1'b0 : (pend_m || coef_swap);
    if (coef_we && coef_addr < TAPS) shd_m[coef_addr] = longint'(coef_wdata);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(ov_m()));
    chk("dout", 64'(dout), 64'(dout_m));
    chk("in_ready", 64'(in_ready), 64'(!ov_m() || out_ready));
    chk("swap_pending", 64'(swap_pending), 64'(pend_m));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    coef_we   = 1'b0;
    coef_swap = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic send(input int x, input bit rdy);
    in_valid  = 1'b1;
    din       = DATA_W'(x);
    out_ready = rdy;
    cycle();
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic load_bank(input int h0, input int h1, input int h2, input int h3, input bit do_swap);
    int hv [TAPS];
    hv[0] = h0; hv[1] = h1; hv[2] = h2; hv[3] = h3;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      coef_we    = 1'b1;
      coef_addr  = ADDR_W'(k);
      coef_wdata = COEF_W'(hv[k]);
      cycle();
    end
    if (do_swap) begin
      coef_swap = 1'b1;
      cycle();
      cycle();
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; coef_swap = 1'b0;

    // Reset state
    rst_n = 1'b0; cycle();
    rst_n = 1'b0; cycle();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_swap_pending", 64'(swap_pending), 64'(0));

    // Impulse response and latency
    load_bank(2, 4, 6, 8, 1'b1);
    send(1, 1'b1); chk("imp_lat_e0", 64'(out_valid), 64'(0));
    send(0, 1'b1); chk("imp_lat_e1", 64'(out_valid), 64'(0));
    send(0, 1'b1); chk("imp_y0_valid", 64'(out_valid), 64'(1)); chk("imp_y0", 64'(dout), 64'(1));
    send(0, 1'b1); chk("imp_y1", 64'(dout), 64'(2));
    send(0, 1'b1); chk("imp_y2", 64'(dout), 64'(3));
    idle(1);       chk("imp_y3", 64'(dout), 64'(4));
    idle(1);       chk("imp_y4", 64'(dout), 64'(0)); chk("imp_y4_valid", 64'(out_valid), 64'(1));
    idle(2);

    // Rounding half toward +inf
    load_bank(1, 0, 0, 0, 1'b1);
    send(1, 1'b1); send(-1, 1'b1); send(-3, 1'b1);
    chk("rnd_p1", 64'(dout), 64'(1));
    idle(1); chk("rnd_m1", 64'(dout), 64'(0));
    idle(1); chk("rnd_m3", 64'(dout), 64'(-1));
    idle(2);

    // Output overflow: saturate or wrap
    load_bank(32767, 32767, 32767, 32767, 1'b1);
    repeat (4) send(32767, 1'b1);
    idle(2);
`ifdef FIR_SAT_EN
    chk("ovf_y3", 64'(dout), 64'(32767));
`else
    chk("ovf_y3", 64'(dout), 64'(2));
`endif
    idle(2);

    // Backpressure mid-stream with input held valid
    load_bank(rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);
    repeat (6) send(rnd16(), 1'b1);
    repeat (5) begin
      send(rnd16(), 1'b0);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
    end
    repeat (6) send(rnd16(), 1'b1);
    idle(4);

    // Swap requested while stalled; out-of-range write ignored
    load_bank(2, 0, 0, 0, 1'b1);
    load_bank(4, 0, 0, 0, 1'b0);
    coef_we = 1'b1; coef_addr = ADDR_W'(5); coef_wdata = 16'sh1234; in_valid = 1'b0;
    cycle();
    repeat (3) send(rnd16(), 1'b0);
    coef_swap = 1'b1;
    send(rnd16(), 1'b0); chk("sw_pend_set", 64'(swap_pending), 64'(1));
    repeat (3) begin
      send(rnd16(), 1'b0); chk("sw_pend_hold", 64'(swap_pending), 64'(1));
    end
    send(rnd16(), 1'b1); chk("sw_pend_clr", 64'(swap_pending), 64'(0));
    repeat (5) send(rnd16(), 1'b1);
    idle(4);

    // Reset with samples in flight
    send(rnd16(), 1'b1); send(rnd16(), 1'b1);
    rst_n = 1'b0; in_valid = 1'b0;
    cycle();
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_dout", 64'(dout), 64'(0));
    repeat (4) send(rnd16(), 1'b1);
    idle(3);
    chk("mid_rst_zero_coef", 64'(dout), 64'(0));

    // Randomized traffic, coefficient writes and swaps
    repeat (400) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      din        = DATA_W'(rnd16());
      out_ready  = ($urandom_range(0, 3) != 0);
      coef_we    = ($urandom_range(0, 4) == 0);
      coef_addr  = ADDR_W'($urandom_range(0, 7));
      coef_wdata = COEF_W'(rnd16());
      coef_swap  = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
